// File: rtl/control_unit_pkg.sv
// Shared definitions for the control unit slice: FSM state encoding,
// instruction format codes, ALU select codes and instruction field helpers.
package control_unit_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SRC    = 3'd1,
        EXEC   = 3'd2,
        COMMIT = 3'd3,
        WRITE  = 3'd4
    } state_t;

    // Instruction format codes (instruction[1:0])
    localparam logic [1:0] FMT_REG = 2'd0;
    localparam logic [1:0] FMT_IMM = 2'd1;
    localparam logic [1:0] FMT_RSV = 2'd2;
    localparam logic [1:0] FMT_MEM = 2'd3;

    // ALU select codes
    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_SUB  = 3'd1;
    localparam logic [2:0] ALU_AND  = 3'd2;
    localparam logic [2:0] ALU_OR   = 3'd3;
    localparam logic [2:0] ALU_XOR  = 3'd4;
    localparam logic [2:0] ALU_SHL  = 3'd5;
    localparam logic [2:0] ALU_SHR  = 3'd6;
    localparam logic [2:0] ALU_PASS = 3'd7;

    // Field extraction. Ry and imm overlap by design: the format decides
    // which interpretation the datapath uses.
    function automatic logic [2:0] rx_of(input logic [15:0] instr);
        return instr[15:13];
    endfunction

    function automatic logic [1:0] fmt_of(input logic [15:0] instr);
        return instr[1:0];
    endfunction

    // Only register and immediate ops write back to the register file.
    function automatic logic writes_reg(input logic [15:0] instr);
        return (fmt_of(instr) == FMT_REG) || (fmt_of(instr) == FMT_IMM);
    endfunction

endpackage

// File: rtl/control_unit_alu.sv
// alu: registered 16-bit ALU used by the datapath (not by control_unit).
// Ports:
//   clk     - clock, result updates on rising edge
//   run     - enable; 0 holds alu_out
//   in_a    - operand A
//   in_b    - operand B (shift amount taken from in_b[3:0])
//   select  - operation code (ALU_* in control_unit_pkg)
//   alu_out - registered result, modulo 2^16, no flags
module alu
    import control_unit_pkg::*;
(
    input  logic        clk,
    input  logic        run,
    input  logic [15:0] in_a,
    input  logic [15:0] in_b,
    input  logic [2:0]  select,
    output logic [15:0] alu_out
);

    // No reset port: the result register powers up to zero instead.
    logic [15:0] res_q = 16'h0000;
    logic [15:0] res_d;

    always_comb begin
        res_d = 16'h0000;
        case (select)
            ALU_ADD:  res_d = in_a + in_b;
            ALU_SUB:  res_d = in_a - in_b;
            ALU_AND:  res_d = in_a & in_b;
            ALU_OR:   res_d = in_a | in_b;
            ALU_XOR:  res_d = in_a ^ in_b;
            ALU_SHL:  res_d = in_a << in_b[3:0];
            ALU_SHR:  res_d = in_a >> in_b[3:0];
            ALU_PASS: res_d = in_b;
            default:  res_d = 16'h0000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (run)
            res_q <= res_d;
    end

    assign alu_out = res_q;

endmodule

// File: rtl/control_unit.sv
// control_unit: five-state sequencer driving datapath strobes for one
// instruction every five cycles (IDLE -> SRC -> EXEC -> COMMIT -> WRITE).
// Ports:
//   clk         - clock, all state on rising edge
//   reset       - asynchronous active-high reset
//   instruction - {Rx[15:13], Ry[12:10] / imm[12:5], sel[4:2], fmt[1:0]}
//   run         - global enable; 0 freezes all state
//   en_s        - source-latch strobe (SRC)
//   en_c        - commit strobe (COMMIT)
//   en_reg      - one-hot register write enable at latched Rx (WRITE)
//   done        - completion pulse (WRITE)
module control_unit
    import control_unit_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] instruction,
    input  logic        run,
    output logic        en_s,
    output logic        en_c,
    output logic [7:0]  en_reg,
    output logic        done
);

    state_t      state, nxt;
    logic [15:0] instr_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            instr_q <= 16'h0000;
        end else if (run) begin
            state <= nxt;
            // Capture only on the starting edge so later input changes
            // cannot disturb the instruction in flight.
            if (state == IDLE)
                instr_q <= instruction;
        end
    end

    // Moore outputs: a function of the state registers only, so an
    // asynchronous reset clears them in the same cycle.
    always_comb begin
        nxt    = state;
        en_s   = 1'b0;
        en_c   = 1'b0;
        en_reg = 8'h00;
        done   = 1'b0;
        case (state)
            IDLE:   nxt = SRC;
            SRC: begin
                en_s = 1'b1;
                nxt  = EXEC;
            end
            EXEC:   nxt = COMMIT;
            COMMIT: begin
                en_c = 1'b1;
                nxt  = WRITE;
            end
            WRITE: begin
                done = 1'b1;
                if (writes_reg(instr_q))
                    en_reg = 8'(1) << rx_of(instr_q);
                nxt = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit plus directed/random checks of alu.
module tb_control_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] instruction = 16'h0000;
    logic        run = 1'b0;
    logic        en_s, en_c, done;
    logic [7:0]  en_reg;

    logic        a_run = 1'b0;
    logic [15:0] a_in_a = 16'h0000, a_in_b = 16'h0000;
    logic [2:0]  a_sel = 3'd0;
    logic [15:0] a_out;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    control_unit dut (
        .clk(clk), .reset(reset), .instruction(instruction), .run(run),
        .en_s(en_s), .en_c(en_c), .en_reg(en_reg), .done(done)
    );

    alu u_alu (
        .clk(clk), .run(a_run), .in_a(a_in_a), .in_b(a_in_b),
        .select(a_sel), .alu_out(a_out)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // phase = number of run edges taken inside the current instruction
    // (0 = waiting to start). Expected frame = {en_s, en_c, done, en_reg}.
    int          phase = 0;
    logic [15:0] lat = 16'h0000;
    logic [10:0] exp_q[$];

    function automatic logic [10:0] frame_of(input int p, input logic [15:0] ins);
        logic [7:0] r;
        r = 8'h00;
        if (p == 4 && ins[1:0] < 2'd2)
            r = 8'h01 << ins[15:13];
        return {p == 1, p == 3, p == 4, r};
    endfunction

    // Called at posedge+1; drives one cycle worth of inputs.
    task automatic cyc(input bit r, input logic [15:0] ins, input bit rst);
        reset = rst;
        if (rst) begin
            phase = 0;
            lat   = 16'h0000;
        end
        exp_q.push_back(frame_of(phase, lat));
        run = r;
        instruction = ins;
        @(posedge clk);
        if (!reset && run) begin
            if (phase == 0) begin
                phase = 1;
                lat   = instruction;
            end else begin
                phase = (phase == 4) ? 0 : phase + 1;
            end
        end
        #1;
    endtask

    // ---------------- monitor ----------------
    initial begin
        logic [10:0] f;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                f = exp_q.pop_front();
                chk("cu_frame{en_s,en_c,done,en_reg}",
                    {21'd0, en_s, en_c, done, en_reg}, {21'd0, f});
            end
        end
    end

    // ---------------- alu model ----------------
    function automatic logic [15:0] alu_ref(input logic [2:0] s, input logic [15:0] a, input logic [15:0] b);
        int ia, ib, sh;
        ia = a; ib = b; sh = b[3:0];
        case (s)
            3'd0: return 16'((ia + ib) % 65536);
            3'd1: return 16'((ia - ib + 65536) % 65536);
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a ^ b;
            3'd5: return 16'((ia * (1 << sh)) % 65536);
            3'd6: return 16'(ia / (1 << sh));
            default: return b;
        endcase
    endfunction

    task automatic alu_op(input logic [2:0] s, input logic [15:0] a, input logic [15:0] b, input string name);
        a_run = 1'b1; a_sel = s; a_in_a = a; a_in_b = b;
        @(posedge clk); #1;
        chk(name, {16'd0, a_out}, {16'd0, alu_ref(s, a, b)});
    endtask

    initial begin
        logic [15:0] held;
        int wait_cnt;

        // alu power-up value, before any clock edge
        #1;
        chk("alu_powerup", {16'd0, a_out}, 32'd0);

        @(posedge clk); #1;
        alu_op(3'd0, 16'hFFFF, 16'h0001, "alu_add_wrap");
        chk("alu_add_const", {16'd0, a_out}, 32'h0000);
        alu_op(3'd1, 16'h0000, 16'h0001, "alu_sub_wrap");
        chk("alu_sub_const", {16'd0, a_out}, 32'hFFFF);
        alu_op(3'd5, 16'h0001, 16'h0004, "alu_shl");
        chk("alu_shl_const", {16'd0, a_out}, 32'h0010);
        for (int i = 0; i < 24; i++)
            alu_op(3'(i % 8), 16'($urandom), 16'($urandom), "alu_rand");

        // run=0 with changing inputs: output must hold
        held = a_out;
        a_run = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a_sel = 3'($urandom); a_in_a = 16'($urandom); a_in_b = 16'($urandom);
            @(posedge clk); #1;
            chk("alu_hold", {16'd0, a_out}, {16'd0, held});
        end

        // control_unit: reset state
        cyc(0, 16'h0000, 1);
        cyc(1, 16'h0000, 1);
        cyc(0, 16'h0000, 0);

        // register op 0x2400, continuous run
        cyc(1, 16'h2400, 0);
        for (int i = 0; i < 4; i++) cyc(1, 16'($urandom), 0);
        cyc(0, 16'h0000, 0);

        // store, fmt 3
        cyc(1, 16'hE407, 0);
        for (int i = 0; i < 4; i++) cyc(1, 16'($urandom), 0);
        cyc(0, 16'h0000, 0);

        // immediate op, run dropped for 3 cycles while in EXEC
        cyc(1, 16'hA0E5, 0);
        cyc(1, 16'($urandom), 0);
        for (int i = 0; i < 3; i++) cyc(0, 16'($urandom), 0);
        for (int i = 0; i < 3; i++) cyc(1, 16'($urandom), 0);
        cyc(0, 16'h0000, 0);

        // reserved fmt 2 traverses as NOP
        cyc(1, 16'hFFFE, 0);
        for (int i = 0; i < 4; i++) cyc(1, 16'($urandom), 0);
        cyc(0, 16'h0000, 0);

        // reset asserted mid-COMMIT, then restart
        cyc(1, 16'h6000, 0);
        cyc(1, 16'h0000, 0);
        cyc(1, 16'h0000, 0);
        cyc(1, 16'h0000, 1);
        cyc(0, 16'h0000, 0);
        cyc(0, 16'h0000, 0);
        cyc(1, 16'hC001, 0);
        for (int i = 0; i < 5; i++) cyc(1, 16'($urandom), 0);

        // randomized run, instruction and occasional reset
        for (int i = 0; i < 600; i++)
            cyc($urandom_range(0, 3) != 0, 16'($urandom), $urandom_range(0, 59) == 0);

        // drain scoreboard with a bounded wait
        wait_cnt = 0;
        while (exp_q.size() > 0 && wait_cnt < 10) begin
            @(posedge clk); #1;
            wait_cnt++;
        end
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
